// File: rtl/hamming_decoder.sv
// Serial Hamming(7,4) receiver: collects a 7-bit codeword, corrects a
// single-bit error, then presents the data in parallel and serially.
module hamming_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       sof,
  output logic [3:0] data,
  output logic [2:0] syn,
  output logic       err,
  output logic       dvalid,
  output logic       so,
  output logic       so_valid,
  output logic [2:0] count,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CORR,
    SEND
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:1] cw;
  logic [2:0] acc;
  logic [1:0] sidx;
  logic [2:0] pos;
  logic [7:1] fix;
  logic [7:1] cwc;

  assign busy = (state != IDLE);
  assign pos  = count + 3'd1;

  // Syndrome equals the bad position, so the flip mask is its one-hot.
  always_comb begin
    fix = '0;
    for (int i = 1; i <= 7; i++) begin
      fix[i] = (acc == 3'(i));
    end
  end

  assign cwc = cw ^ fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (sof) begin
      state_nx = RECV;
    end else begin
      unique case (state)
        IDLE: state_nx = IDLE;
        RECV: if (count == 3'd6) state_nx = CORR;
        CORR: state_nx = SEND;
        SEND: if (sidx == 2'd3) state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw       <= '0;
      acc      <= '0;
      sidx     <= '0;
      count    <= '0;
      data     <= '0;
      syn      <= '0;
      err      <= 1'b0;
      dvalid   <= 1'b0;
      so       <= 1'b0;
      so_valid <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      if (sof) begin
        cw       <= {6'b0, sin};
        acc      <= {2'b0, sin};
        count    <= 3'd1;
        sidx     <= '0;
        so       <= 1'b0;
        so_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          RECV: begin
            cw[pos] <= sin;
            acc     <= acc ^ (sin ? pos : 3'd0);
            count   <= pos;
          end
          CORR: begin
            data     <= {cwc[3], cwc[5], cwc[6], cwc[7]};
            syn      <= acc;
            err      <= |acc;
            dvalid   <= 1'b1;
            so       <= cwc[3];
            so_valid <= 1'b1;
            count    <= '0;
            sidx     <= '0;
          end
          SEND: begin
            sidx <= sidx + 2'd1;
            unique case (sidx)
              2'd0: so <= data[2];
              2'd1: so <= data[1];
              2'd2: so <= data[0];
              2'd3: begin
                so       <= 1'b0;
                so_valid <= 1'b0;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder with an expected-result queue
// filled when a frame is sent and drained when dvalid appears.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       sof = 1'b0;
  logic [3:0] data;
  logic [2:0] syn;
  logic       err;
  logic       dvalid;
  logic       so;
  logic       so_valid;
  logic [2:0] count;
  logic       busy;

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] s;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   dv_cnt = 0;
  int   base;

  hamming_decoder dut (
    .clk(clk),
    .rst(rst),
    .sin(sin),
    .sof(sof),
    .data(data),
    .syn(syn),
    .err(err),
    .dvalid(dvalid),
    .so(so),
    .so_valid(so_valid),
    .count(count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dvalid === 1'b1) dv_cnt <= dv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic [2:0] s,
                      input logic e);
    exp_t x;
    x.d = d;
    x.s = s;
    x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [6:0] cw, input bit now);
    for (int i = 0; i < 7; i++) begin
      if (!(now && i == 0)) @(negedge clk);
      if (i == 1) begin
        chk("cnt1", 32'(count), 1);
        chk("sov_rx", 32'(so_valid), 0);
        chk("busy_rx", 32'(busy), 1);
      end
      sin = cw[6-i];
      sof = (i == 0);
    end
  endtask

  task automatic check_result(input int nso);
    exp_t e;
    @(negedge clk);
    sin = 1'b0;
    sof = 1'b0;
    chk("cnt7", 32'(count), 7);
    chk("dv_early", 32'(dvalid), 0);
    @(negedge clk);
    chk("dv", 32'(dvalid), 1);
    chk("sb_has", 32'(exp_q.size() != 0), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("data", 32'(data), 32'(e.d));
    chk("syn", 32'(syn), 32'(e.s));
    chk("err", 32'(err), 32'(e.e));
    chk("cnt0", 32'(count), 0);
    chk("busy_tx", 32'(busy), 1);
    chk("sov", 32'(so_valid), 1);
    chk("so_d1", 32'(so), 32'(e.d[3]));
    for (int i = 1; i < nso; i++) begin
      @(negedge clk);
      chk("so_dn", 32'(so), 32'(e.d[3-i]));
      chk("sov_n", 32'(so_valid), 1);
      chk("dv_once", 32'(dvalid), 0);
    end
    if (nso == 4) begin
      @(negedge clk);
      chk("sov_end", 32'(so_valid), 0);
      chk("so_end", 32'(so), 0);
      chk("busy_end", 32'(busy), 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(data), 0);
    chk("rst_syn", 32'(syn), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dv", 32'(dvalid), 0);
    chk("rst_so", 32'(so), 0);
    chk("rst_sov", 32'(so_valid), 0);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_busy", 32'(busy), 0);

    // clean frame, sof on the first edge after reset release
    rst = 1'b0;
    base = dv_cnt;
    push(4'b1011, 3'b000, 1'b0);
    send_frame(7'b0110011, 1'b1);
    check_result(4);
    chk("dv_cnt_clean", 32'(dv_cnt - base), 1);

    // single data-bit error at position 5
    push(4'b1011, 3'b101, 1'b1);
    send_frame(7'b0110111, 1'b0);
    check_result(4);

    // parity-bit error at position 1, then a clean frame
    push(4'b1011, 3'b001, 1'b1);
    send_frame(7'b1110011, 1'b0);
    check_result(4);
    push(4'b1001, 3'b000, 1'b0);
    send_frame(7'b0011001, 1'b0);
    check_result(4);

    // abort at bit 4 of a frame
    base = dv_cnt;
    @(negedge clk); sin = 1'b1; sof = 1'b1;
    @(negedge clk); sin = 1'b0; sof = 1'b0;
    @(negedge clk); sin = 1'b1;
    push(4'b1011, 3'b000, 1'b0);
    send_frame(7'b0110011, 1'b0);
    check_result(4);
    chk("dv_cnt_abort", 32'(dv_cnt - base), 1);

    // reset at bit 3
    base = dv_cnt;
    @(negedge clk); sin = 1'b0; sof = 1'b1;
    @(negedge clk); sin = 1'b1; sof = 1'b0;
    @(negedge clk); sin = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr_data", 32'(data), 0);
    chk("mr_syn", 32'(syn), 0);
    chk("mr_err", 32'(err), 0);
    chk("mr_so", 32'(so), 0);
    chk("mr_sov", 32'(so_valid), 0);
    chk("mr_cnt", 32'(count), 0);
    chk("mr_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    sin = 1'b1;
    sof = 1'b0;
    repeat (12) @(negedge clk);
    chk("mr_nodv", 32'(dv_cnt - base), 0);
    chk("mr_idle", 32'(busy), 0);
    push(4'b1001, 3'b000, 1'b0);
    send_frame(7'b0011001, 1'b0);
    check_result(4);

    // back-to-back: next sof during SEND cycle 2
    base = dv_cnt;
    push(4'b1011, 3'b000, 1'b0);
    send_frame(7'b0110011, 1'b0);
    check_result(2);
    push(4'b1001, 3'b100, 1'b1);
    send_frame(7'b0010001, 1'b1);
    check_result(4);
    chk("dv_cnt_b2b", 32'(dv_cnt - base), 2);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
